// File: rtl/multi_cycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle CPU datapath and its
// main control FSM. The controller connects through the slave modport; the
// datapath (or a bench standing in for it) uses the master modport.
interface multi_cycle_ctrl_if;
    logic [5:0] opcode_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       iord_o;
    logic       ir_write_o;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic [1:0] pc_src_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic       reg_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       illegal_o;
    logic       bus_err_o;
    logic [3:0] state_o;

    modport master (
        output opcode_i, zero_i, mem_ready_i,
        input  mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
               pc_write_cond_o, pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o, bus_err_o, state_o
    );

    modport slave (
        input  opcode_i, zero_i, mem_ready_i,
        output mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
               pc_write_cond_o, pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o, bus_err_o, state_o
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle CPU. Steps one shared ALU and one
// shared memory port through fetch/decode/execute/mem/writeback, stalls on
// the memory ready handshake and aborts a memory access that hangs longer
// than TIMEOUT wait cycles (TIMEOUT = 0 waits forever).
module multi_cycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multi_cycle_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXR  = 4'd6,
        S_WBR  = 4'd7,
        S_EXI  = 4'd8,
        S_WBI  = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             slti;      // EXI selects slti vs addi from what ID saw
    logic             slti_next;
    logic             mem_wait;
    logic             timeout;
    logic             illegal;

    // State, wait counter and the decoded slti flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IF;
            cnt   <= '0;
            slti  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            slti  <= slti_next;
        end
    end

    // Next state, illegal-opcode detect, timeout detect and wait counter update
    always_comb begin
        state_next = state;
        slti_next  = slti;
        illegal    = 1'b0;
        mem_wait   = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
        timeout    = mem_wait && (TIMEOUT != 0) && (cnt == CNT_LIMIT) && !bus.mem_ready_i;
        case (state)
            S_IF: begin
                if (bus.mem_ready_i) state_next = S_ID;
            end
            S_ID: begin
                slti_next = (bus.opcode_i == OP_SLTI);
                case (bus.opcode_i)
                    OP_RTYPE:        state_next = S_EXR;
                    OP_ADDI, OP_SLTI: state_next = S_EXI;
                    OP_LW, OP_SW:    state_next = S_MADR;
                    OP_BEQ:          state_next = S_BR;
                    OP_J:            state_next = S_JMP;
                    default: begin
                        state_next = S_IF;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MADR: begin
                if (bus.opcode_i == OP_LW)      state_next = S_MRD;
                else if (bus.opcode_i == OP_SW) state_next = S_MWR;
                else                            state_next = S_IF;
            end
            S_MRD: begin
                if (bus.mem_ready_i) state_next = S_MWB;
                else if (timeout)    state_next = S_IF;
            end
            S_MWR: begin
                if (bus.mem_ready_i || timeout) state_next = S_IF;
            end
            S_EXR:   state_next = S_WBR;
            S_EXI:   state_next = S_WBI;
            default: state_next = S_IF;
        endcase
        // An abort in IF re-enters IF, so the counter must also clear on timeout
        if ((state_next != state) || timeout)
            cnt_next = '0;
        else if (mem_wait && !bus.mem_ready_i && (cnt != CNT_MAX))
            cnt_next = cnt + 1'b1;
        else
            cnt_next = cnt;
    end

    // Control outputs decoded from state; forced to idle values while in reset
    always_comb begin
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.iord_o          = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.pc_write_o      = 1'b0;
        bus.pc_write_cond_o = 1'b0;
        bus.pc_src_o        = 2'd0;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = 2'd0;
        bus.alu_op_o        = 3'b010;
        bus.reg_write_o     = 1'b0;
        bus.reg_dst_o       = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.illegal_o       = 1'b0;
        bus.bus_err_o       = 1'b0;
        bus.state_o         = state;
        if (rst_i) begin
            bus.illegal_o = illegal;
            bus.bus_err_o = timeout;
            case (state)
                S_IF: begin
                    bus.mem_read_o  = 1'b1;
                    bus.alu_src_b_o = 2'd1;
                    bus.ir_write_o  = bus.mem_ready_i;
                    bus.pc_write_o  = bus.mem_ready_i;
                end
                S_ID: bus.alu_src_b_o = 2'd3;
                S_MADR: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_src_b_o = 2'd2;
                end
                S_MRD: begin
                    bus.mem_read_o = 1'b1;
                    bus.iord_o     = 1'b1;
                end
                S_MWB: begin
                    bus.reg_write_o  = 1'b1;
                    bus.mem_to_reg_o = 1'b1;
                end
                S_MWR: begin
                    // A write that is being aborted must not land
                    bus.mem_write_o = !timeout;
                    bus.iord_o      = 1'b1;
                end
                S_EXR: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_op_o    = 3'b100;
                end
                S_WBR: begin
                    bus.reg_write_o = 1'b1;
                    bus.reg_dst_o   = 1'b1;
                end
                S_EXI: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_src_b_o = 2'd2;
                    bus.alu_op_o    = slti ? 3'b001 : 3'b010;
                end
                S_WBI: bus.reg_write_o = 1'b1;
                S_BR: begin
                    bus.alu_src_a_o     = 1'b1;
                    bus.alu_op_o        = 3'b011;
                    bus.pc_write_cond_o = 1'b1;
                    bus.pc_src_o        = 2'd1;
                end
                S_JMP: begin
                    bus.pc_write_o = 1'b1;
                    bus.pc_src_o   = 2'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and randomized instruction streams checked against
// an instruction-level reference model.
module tb_multi_cycle_ctrl;

    localparam int TIMEOUT = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic       bus_err;
    } out_t;

    typedef struct {
        logic [5:0] opcode;
        logic       ready;
        logic       zero;
        out_t       exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    vec_t q[$];
    vec_t tbl[14];

    out_t e_rst, e_if_wait, e_if_go, e_id, e_madr, e_mrd, e_mwb, e_mwr;
    out_t e_exr, e_wbr, e_exi_add, e_exi_slti, e_wbi, e_br, e_jmp;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t rec(input int st, input bit mr, mw, io, irw, pcw, pcc,
                                 input int pcs, input bit sa, input int sb,
                                 input logic [2:0] op, input bit rw, rd, m2r, ill, be);
        out_t r;
        r.state = 4'(st);      r.mem_read = mr;       r.mem_write = mw;
        r.iord = io;           r.ir_write = irw;      r.pc_write = pcw;
        r.pc_write_cond = pcc; r.pc_src = 2'(pcs);    r.src_a = sa;
        r.src_b = 2'(sb);      r.alu_op = op;         r.reg_write = rw;
        r.reg_dst = rd;        r.mem_to_reg = m2r;    r.illegal = ill;
        r.bus_err = be;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [5:0] op, input logic rdy, input logic z, input out_t e);
        vec_t v;
        v.opcode = op; v.ready = rdy; v.zero = z; v.exp = e;
        return v;
    endfunction

    function automatic out_t sample();
        out_t g;
        g.state = bus.state_o;             g.mem_read = bus.mem_read_o;
        g.mem_write = bus.mem_write_o;     g.iord = bus.iord_o;
        g.ir_write = bus.ir_write_o;       g.pc_write = bus.pc_write_o;
        g.pc_write_cond = bus.pc_write_cond_o;
        g.pc_src = bus.pc_src_o;           g.src_a = bus.alu_src_a_o;
        g.src_b = bus.alu_src_b_o;         g.alu_op = bus.alu_op_o;
        g.reg_write = bus.reg_write_o;     g.reg_dst = bus.reg_dst_o;
        g.mem_to_reg = bus.mem_to_reg_o;   g.illegal = bus.illegal_o;
        g.bus_err = bus.bus_err_o;
        return g;
    endfunction

    task automatic check(input out_t exp, input string name);
        out_t got;
        got = sample();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, check on the falling edge
    task automatic step(input vec_t v, input string name);
        bus.opcode_i    = v.opcode;
        bus.mem_ready_i = v.ready;
        bus.zero_i      = v.zero;
        @(negedge clk);
        check(v.exp, name);
        @(posedge clk);
        #1;
    endtask

    task automatic step_e(input logic [5:0] op, input logic rdy, input out_t e, input string name);
        step(mkv(op, rdy, 1'($urandom), e), name);
    endtask

    // ---------------- instruction-level reference model ----------------
    function automatic bit known(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    // Opcode only matters in decode and address calculation; elsewhere drive noise.
    // rdy==2 means the memory handshake is irrelevant this cycle: drive noise.
    function automatic void push(input bit sampled, input logic [5:0] op, input int rdy, input out_t e);
        logic [5:0] o;
        logic       r;
        o = sampled ? op : 6'($urandom);
        r = (rdy == 2) ? 1'($urandom) : 1'(rdy);
        q.push_back(mkv(o, r, 1'($urandom), e));
    endfunction

    // One memory access that sees w not-ready cycles before ready; returns 1 if aborted
    function automatic bit mem_phase(input out_t base, input int w, input bit fetch);
        out_t e;
        if (TIMEOUT != 0 && w > TIMEOUT) begin
            for (int i = 0; i <= TIMEOUT; i++) begin
                e = base;
                if (i == TIMEOUT) begin
                    e.bus_err   = 1'b1;
                    e.mem_write = 1'b0;
                end
                push(0, 6'd0, 0, e);
            end
            return 1'b1;
        end
        for (int i = 0; i < w; i++) push(0, 6'd0, 0, base);
        e = base;
        if (fetch) begin
            e.ir_write = 1'b1;
            e.pc_write = 1'b1;
        end
        push(0, 6'd0, 1, e);
        return 1'b0;
    endfunction

    function automatic void model_instr(input logic [5:0] op, input int w_if, input int w_mem);
        out_t e;
        bit   ab;
        if (mem_phase(e_if_wait, w_if, 1)) return;
        e = e_id;
        e.illegal = !known(op);
        push(1, op, 2, e);
        if (!known(op)) return;
        case (op)
            OP_R:    begin push(0, op, 2, e_exr); push(0, op, 2, e_wbr); end
            OP_ADDI: begin push(0, op, 2, e_exi_add); push(0, op, 2, e_wbi); end
            OP_SLTI: begin push(0, op, 2, e_exi_slti); push(0, op, 2, e_wbi); end
            OP_LW: begin
                push(1, op, 2, e_madr);
                ab = mem_phase(e_mrd, w_mem, 0);
                if (!ab) push(0, op, 2, e_mwb);
            end
            OP_SW: begin
                push(1, op, 2, e_madr);
                ab = mem_phase(e_mwr, w_mem, 0);
            end
            OP_BEQ:  push(0, op, 2, e_br);
            default: push(0, op, 2, e_jmp);
        endcase
    endfunction

    function automatic int rand_wait();
        if ($urandom_range(0, 4) == 0) return $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
        return $urandom_range(0, 3);
    endfunction

    task automatic run_queue(input string tag);
        int n;
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front(), $sformatf("%s[%0d]", tag, n));
            n++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0] op;
        logic [5:0] ops[8];

        //               st mr mw io irw pcw pcc pcs sa sb  op     rw rd m2r ill be
        e_rst      = rec(0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 3'b010, 0, 0, 0,  0,  0);
        e_if_wait  = rec(0, 1, 0, 0, 0,  0,  0,  0,  0, 1, 3'b010, 0, 0, 0,  0,  0);
        e_if_go    = rec(0, 1, 0, 0, 1,  1,  0,  0,  0, 1, 3'b010, 0, 0, 0,  0,  0);
        e_id       = rec(1, 0, 0, 0, 0,  0,  0,  0,  0, 3, 3'b010, 0, 0, 0,  0,  0);
        e_madr     = rec(2, 0, 0, 0, 0,  0,  0,  0,  1, 2, 3'b010, 0, 0, 0,  0,  0);
        e_mrd      = rec(3, 1, 0, 1, 0,  0,  0,  0,  0, 0, 3'b010, 0, 0, 0,  0,  0);
        e_mwb      = rec(4, 0, 0, 0, 0,  0,  0,  0,  0, 0, 3'b010, 1, 0, 1,  0,  0);
        e_mwr      = rec(5, 0, 1, 1, 0,  0,  0,  0,  0, 0, 3'b010, 0, 0, 0,  0,  0);
        e_exr      = rec(6, 0, 0, 0, 0,  0,  0,  0,  1, 0, 3'b100, 0, 0, 0,  0,  0);
        e_wbr      = rec(7, 0, 0, 0, 0,  0,  0,  0,  0, 0, 3'b010, 1, 1, 0,  0,  0);
        e_exi_add  = rec(8, 0, 0, 0, 0,  0,  0,  0,  1, 2, 3'b010, 0, 0, 0,  0,  0);
        e_exi_slti = rec(8, 0, 0, 0, 0,  0,  0,  0,  1, 2, 3'b001, 0, 0, 0,  0,  0);
        e_wbi      = rec(9, 0, 0, 0, 0,  0,  0,  0,  0, 0, 3'b010, 1, 0, 0,  0,  0);
        e_br       = rec(10,0, 0, 0, 0,  0,  1,  1,  1, 0, 3'b011, 0, 0, 0,  0,  0);
        e_jmp      = rec(11,0, 0, 0, 0,  1,  0,  2,  0, 0, 3'b010, 0, 0, 0,  0,  0);

        tbl[0]  = mkv(OP_R,    1, 0, e_if_go);
        tbl[1]  = mkv(OP_R,    1, 0, e_id);
        tbl[2]  = mkv(OP_R,    1, 0, e_exr);
        tbl[3]  = mkv(OP_R,    1, 0, e_wbr);
        tbl[4]  = mkv(OP_BEQ,  1, 1, e_if_go);
        tbl[5]  = mkv(OP_BEQ,  1, 1, e_id);
        tbl[6]  = mkv(OP_BEQ,  1, 1, e_br);
        tbl[7]  = mkv(OP_SLTI, 1, 0, e_if_go);
        tbl[8]  = mkv(OP_SLTI, 1, 0, e_id);
        tbl[9]  = mkv(6'h3f,   0, 0, e_exi_slti);
        tbl[10] = mkv(OP_J,    1, 0, e_wbi);
        tbl[11] = mkv(OP_J,    1, 0, e_if_go);
        tbl[12] = mkv(OP_J,    1, 0, e_id);
        tbl[13] = mkv(OP_J,    1, 0, e_jmp);

        ops = '{OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J, 6'h3f};

        bus.opcode_i    = 6'd0;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b1;

        // Reset held: idle outputs even though memory reports ready
        repeat (2) @(posedge clk);
        #1;
        check(e_rst, "reset_hold");
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl[%0d]", i));

        // lw with three not-ready cycles in MRD: 8 cycles total
        step_e(OP_LW, 1, e_if_go, "lw_if");
        step_e(OP_LW, 0, e_id, "lw_id");
        step_e(OP_LW, 0, e_madr, "lw_madr");
        for (int i = 0; i < 3; i++) step_e(6'h00, 0, e_mrd, $sformatf("lw_mrd_wait%0d", i));
        step_e(6'h2b, 1, e_mrd, "lw_mrd_ready");
        step_e(6'h2b, 0, e_mwb, "lw_mwb");

        // Unknown opcode: illegal pulse in ID, then straight back to fetch
        step_e(6'h3f, 1, e_if_go, "ill_if");
        step_e(6'h3f, 1, rec(1,0,0,0,0,0,0,0,0,3,3'b010,0,0,0,1,0), "ill_id");
        step_e(OP_SW, 0, e_if_wait, "ill_back_if");

        // sw with memory stuck: bus error on the 16th MWR cycle, write withheld
        step_e(OP_SW, 1, e_if_go, "sw_if");
        step_e(OP_SW, 1, e_id, "sw_id");
        step_e(OP_SW, 1, e_madr, "sw_madr");
        for (int i = 0; i < TIMEOUT; i++) step_e(OP_LW, 0, e_mwr, $sformatf("sw_mwr_wait%0d", i));
        step_e(OP_LW, 0, rec(5,0,0,1,0,0,0,0,0,0,3'b010,0,0,0,0,1), "sw_timeout");
        step_e(OP_LW, 0, e_if_wait, "sw_after_abort");

        // Reset mid-access in MRD, then the fetch wait counter must start from 0
        step_e(OP_LW, 1, e_if_go, "rst_if");
        step_e(OP_LW, 0, e_id, "rst_id");
        step_e(OP_LW, 0, e_madr, "rst_madr");
        step_e(OP_LW, 0, e_mrd, "rst_mrd0");
        step_e(OP_LW, 0, e_mrd, "rst_mrd1");
        rst_n = 1'b0;
        #1;
        check(e_rst, "rst_mid_access");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) step_e(OP_LW, 0, e_if_wait, $sformatf("rst_if_wait%0d", i));
        step_e(OP_LW, 0, rec(0,1,0,0,0,0,0,0,0,1,3'b010,0,0,0,0,1), "rst_if_timeout");

        // Model-driven boundary cases: ready exactly at the limit, and one past it
        model_instr(OP_LW, 0, TIMEOUT);
        model_instr(OP_SW, TIMEOUT, 0);
        model_instr(OP_LW, 0, TIMEOUT + 1);
        model_instr(OP_ADDI, TIMEOUT + 1, 0);
        run_queue("edge");

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'h3f) begin
                op = 6'($urandom);
                while (known(op)) op = 6'($urandom);
            end
            model_instr(op, rand_wait(), rand_wait());
            run_queue($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
